// File: rtl/fishbowl_pkg.sv
// Shared definitions for the fish-tank command link: frame header, command
// codes, error codes and the frame parser state encoding.
package fishbowl_pkg;

    localparam logic [7:0] HDR       = 8'hAA;

    localparam logic [7:0] CMD_PUMP  = 8'h01;
    localparam logic [7:0] CMD_LIGHT = 8'h02;
    localparam logic [7:0] CMD_TEMP  = 8'h03;
    localparam logic [7:0] CMD_FEED  = 8'h04;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_LEN  = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4
    } state_t;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle timer. Down-counter reloaded on clear; expire pulses while
// enabled and the count has reached zero, unless a clear lands the same cycle.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYC = 156250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    // Reload on clear, otherwise count down while enabled and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = enable && !clear && (cnt == '0);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles HDR/CMD/LEN/DATA/CHK frames from the UART byte stream and
// publishes good frames to the tank control logic.
//
//  state       | meaning
//  ST_IDLE     | hunting for the header byte; other bytes dropped
//  ST_GET_CMD  | next byte is the command
//  ST_GET_LEN  | next byte is the payload length
//  ST_GET_DATA | collecting payload bytes into the shadow buffer
//  ST_GET_CHK  | next byte is the checksum; commit or reject
module uart_frame_parser #(
    parameter logic [7:0] HDR         = fishbowl_pkg::HDR,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 156250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             din,
    input  logic                   din_vld,
    output logic                   frame_vld,
    output logic [7:0]             cmd,
    output logic [3:0]             len,
    output logic [MAX_LEN*8-1:0]   payload,
    output logic                   err,
    output logic [1:0]             err_code
);

    import fishbowl_pkg::*;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] cmd_s;
    logic [3:0] len_s;
    logic [7:0] buf_s [MAX_LEN];
    logic [7:0] sum;
    logic [3:0] idx;

    logic       tmo_clear;
    logic       tmo_en;
    logic       tmo_expire;

    logic       do_commit;
    logic       do_err;
    err_code_t  err_code_nxt;

    assign tmo_en    = (state != ST_IDLE);
    assign tmo_clear = din_vld || (state == ST_IDLE);

    frame_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_en),
        .expire (tmo_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus commit/error requests; a byte always beats an expiring timer.
    always_comb begin
        state_nxt    = state;
        do_commit    = 1'b0;
        do_err       = 1'b0;
        err_code_nxt = ERR_NONE;
        if (din_vld) begin
            case (state)
                ST_IDLE: begin
                    if (din == HDR) begin
                        state_nxt = ST_GET_CMD;
                    end
                end
                ST_GET_CMD: begin
                    state_nxt = ST_GET_LEN;
                end
                ST_GET_LEN: begin
                    if (din > 8'(MAX_LEN)) begin
                        do_err       = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = ST_IDLE;
                    end else if (din == 8'h00) begin
                        state_nxt = ST_GET_CHK;
                    end else begin
                        state_nxt = ST_GET_DATA;
                    end
                end
                ST_GET_DATA: begin
                    if (idx == (len_s - 4'd1)) begin
                        state_nxt = ST_GET_CHK;
                    end
                end
                ST_GET_CHK: begin
                    if (din == sum) begin
                        do_commit = 1'b1;
                    end else begin
                        do_err       = 1'b1;
                        err_code_nxt = ERR_CHK;
                    end
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (tmo_expire) begin
            do_err       = 1'b1;
            err_code_nxt = ERR_TIMEOUT;
            state_nxt    = ST_IDLE;
        end
    end

    // Shadow registers: command, length, payload buffer, running checksum and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_s <= 8'h00;
            len_s <= 4'd0;
            sum   <= 8'h00;
            idx   <= 4'd0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_s[i] <= 8'h00;
            end
        end else if (din_vld) begin
            case (state)
                ST_IDLE: begin
                    sum <= 8'h00;
                end
                ST_GET_CMD: begin
                    cmd_s <= din;
                    sum   <= sum + din;
                end
                ST_GET_LEN: begin
                    len_s <= din[3:0];
                    sum   <= sum + din;
                    idx   <= 4'd0;
                end
                ST_GET_DATA: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx == 4'(i)) begin
                            buf_s[i] <= din;
                        end
                    end
                    sum <= sum + din;
                    idx <= idx + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Published outputs: load from the shadow regs on commit, zero-filling bytes past len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_vld <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            cmd       <= 8'h00;
            len       <= 4'd0;
            payload   <= '0;
        end else begin
            frame_vld <= do_commit;
            err       <= do_err;
            if (do_err) begin
                err_code <= err_code_nxt;
            end
            if (do_commit) begin
                cmd <= cmd_s;
                len <= len_s;
                for (int i = 0; i < MAX_LEN; i++) begin
                    payload[8*i +: 8] <= (4'(i) < len_s) ? buf_s[i] : 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limit,
// timeout and its byte-wins corner, noise, back-to-back frames, mid-frame reset.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 8;
    localparam int T       = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           din = 8'h00;
    logic                 din_vld = 1'b0;
    logic                 frame_vld;
    logic [7:0]           cmd;
    logic [3:0]           len;
    logic [MAX_LEN*8-1:0] payload;
    logic                 err;
    logic [1:0]           err_code;

    int n_assert = 0;
    int n_fail   = 0;
    int n_err    = 0;
    int n_fv     = 0;
    int n_both   = 0;
    int e0;
    int f0;

    uart_frame_parser #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .frame_vld (frame_vld),
        .cmd       (cmd),
        .len       (len),
        .payload   (payload),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (err) n_err++;
        if (frame_vld) n_fv++;
        if (err && frame_vld) n_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns 1 ns after the capturing edge.
    task automatic send(input logic [7:0] b);
        din     = b;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_frame_vld", 64'(frame_vld), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_cmd", 64'(cmd), 64'd0);
        check("rst_len", 64'(len), 64'd0);
        check("rst_payload", payload, 64'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: good frame, checksum 01+02+11+22 = 36
        send(8'hAA); send(8'h01); send(8'h02); send(8'h11); send(8'h22);
        check("t1_pre_chk_vld", 64'(frame_vld), 64'd0);
        send(8'h36);
        check("t1_frame_vld", 64'(frame_vld), 64'd1);
        check("t1_cmd", 64'(cmd), 64'h01);
        check("t1_len", 64'(len), 64'd2);
        check("t1_payload", payload, 64'h2211);
        idle(1);
        check("t1_vld_one_cycle", 64'(frame_vld), 64'd0);

        // 2: bad checksum (sum 08, sent 00)
        e0 = n_err;
        send(8'hAA); send(8'h02); send(8'h01); send(8'h05);
        check("t2_no_early_err", 64'(n_err - e0), 64'd0);
        send(8'h00);
        check("t2_err", 64'(err), 64'd1);
        check("t2_err_code", 64'(err_code), 64'd1);
        check("t2_no_vld", 64'(frame_vld), 64'd0);
        check("t2_cmd_held", 64'(cmd), 64'h01);
        check("t2_len_held", 64'(len), 64'd2);
        check("t2_payload_held", payload, 64'h2211);
        idle(1);
        check("t2_err_one_cycle", 64'(err), 64'd0);
        check("t2_code_held", 64'(err_code), 64'd1);

        // 3: length 9 > MAX_LEN, then zero-length frame, then MAX_LEN frame
        send(8'hAA); send(8'h03); send(8'h09);
        check("t3_len_err", 64'(err), 64'd1);
        check("t3_len_code", 64'(err_code), 64'd2);
        send(8'hAA); send(8'h04); send(8'h00); send(8'h04);
        check("t3_z_vld", 64'(frame_vld), 64'd1);
        check("t3_z_cmd", 64'(cmd), 64'h04);
        check("t3_z_len", 64'(len), 64'd0);
        check("t3_z_payload", payload, 64'd0);
        check("t3_code_held", 64'(err_code), 64'd2);
        // 05+08+(1+..+8) = 31
        send(8'hAA); send(8'h05); send(8'h08);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h31);
        check("t3_max_vld", 64'(frame_vld), 64'd1);
        check("t3_max_len", 64'(len), 64'd8);
        check("t3_max_payload", payload, 64'h0807060504030201);

        // 4: timeout after T silent cycles
        e0 = n_err;
        send(8'hAA); send(8'h01);
        idle(T - 1);
        check("t4_no_err_before", 64'(n_err - e0), 64'd0);
        idle(1);
        check("t4_tmo_err", 64'(err), 64'd1);
        check("t4_tmo_code", 64'(err_code), 64'd3);
        idle(1);
        check("t4_tmo_one_cycle", 64'(err), 64'd0);
        send(8'hAA); send(8'h02); send(8'h00); send(8'h02);
        check("t4_idle_vld", 64'(frame_vld), 64'd1);
        check("t4_idle_cmd", 64'(cmd), 64'h02);
        // byte lands on the expiry cycle: no timeout
        e0 = n_err;
        send(8'hAA); send(8'h01);
        idle(T - 1);
        send(8'h00);
        check("t4_edge_no_err", 64'(err), 64'd0);
        send(8'h01);
        check("t4_edge_vld", 64'(frame_vld), 64'd1);
        check("t4_edge_cmd", 64'(cmd), 64'h01);
        check("t4_edge_err_cnt", 64'(n_err - e0), 64'd0);

        // 5: noise then a frame; short payload must zero-fill above len
        e0 = n_err;
        send(8'h55); send(8'h00); send(8'hFF);
        send(8'hAA); send(8'h02); send(8'h01); send(8'h7F); send(8'h82);
        check("t5_vld", 64'(frame_vld), 64'd1);
        check("t5_cmd", 64'(cmd), 64'h02);
        check("t5_len", 64'(len), 64'd1);
        check("t5_payload", payload, 64'h7F);
        check("t5_no_err", 64'(n_err - e0), 64'd0);
        // back-to-back, no gap: sums 03+01+10=14, 04+02+01+02=09
        idle(1);
        f0 = n_fv;
        send(8'hAA); send(8'h03); send(8'h01); send(8'h10); send(8'h14);
        check("t5_a_vld", 64'(frame_vld), 64'd1);
        check("t5_a_cmd", 64'(cmd), 64'h03);
        check("t5_a_payload", payload, 64'h10);
        send(8'hAA); send(8'h04); send(8'h02); send(8'h01); send(8'h02); send(8'h09);
        check("t5_b_vld", 64'(frame_vld), 64'd1);
        check("t5_b_cmd", 64'(cmd), 64'h04);
        check("t5_b_payload", payload, 64'h0201);
        idle(1);
        check("t5_two_pulses", 64'(n_fv - f0), 64'd2);

        // 6: reset mid-frame
        e0 = n_err;
        send(8'hAA); send(8'h01); send(8'h02); send(8'h11);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd", 64'(cmd), 64'd0);
        check("t6_rst_len", 64'(len), 64'd0);
        check("t6_rst_payload", payload, 64'd0);
        check("t6_rst_code", 64'(err_code), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("t6_no_err", 64'(n_err - e0), 64'd0);
        send(8'hAA); send(8'h01); send(8'h02); send(8'h11); send(8'h22); send(8'h36);
        check("t6_vld", 64'(frame_vld), 64'd1);
        check("t6_cmd", 64'(cmd), 64'h01);
        check("t6_payload", payload, 64'h2211);
        idle(2);

        check("never_vld_and_err", 64'(n_both), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
